// File: rtl/icblbc_align_distance.sv
// Minimum Hamming distance of the shorter codeword over all alignments within the longer one.
// Optional ICBLBC_EARLY_EXIT_EN: leave SCAN as soon as a zero-distance alignment is found.
module icblbc_align_distance #(
  parameter int unsigned W  = 8,
  parameter int unsigned DW = 4
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  val_a,
  input  logic [3:0]    len_a,
  input  logic [W-1:0]  val_b,
  input  logic [3:0]    len_b,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] distance,
  output logic          error,
  output logic          busy
);

  localparam int unsigned LW = 4;
  localparam logic [LW-1:0] MAX_LEN = LW'(W);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  l_q, l_d;
  logic [W-1:0]  s_q, s_d;
  logic [W-1:0]  mask_q, mask_d;
  logic [LW-1:0] k_q, k_d;
  logic [LW-1:0] kmax_q, kmax_d;
  logic [DW-1:0] min_q, min_d;
  logic          in_ready_q, in_ready_d;
  logic          out_valid_q, out_valid_d;
  logic [DW-1:0] distance_q, distance_d;
  logic          error_q, error_d;
  logic          busy_q, busy_d;

  // Pair decode for the accept cycle: ordering, mask and shift range
  logic          len_ok_c;
  logic          a_is_l_c;
  logic [LW-1:0] ls_c;
  logic [W:0]    mask_wide_c;

  always_comb begin
    len_ok_c    = (len_a != '0) && (len_a <= MAX_LEN) &&
                  (len_b != '0) && (len_b <= MAX_LEN);
    a_is_l_c    = (len_a >= len_b);
    ls_c        = a_is_l_c ? len_b : len_a;
    mask_wide_c = ((W+1)'(1) << ls_c) - (W+1)'(1);
  end

  // Distance at the current alignment
  logic [W-1:0]  diff_c;
  logic [DW-1:0] dk_c;
  logic          last_c;

  always_comb begin
    diff_c = ((l_q >> k_q) ^ s_q) & mask_q;
    dk_c   = '0;
    for (int i = 0; i < W; i++) begin
      dk_c = dk_c + DW'(diff_c[i]);
    end
`ifdef ICBLBC_EARLY_EXIT_EN
    last_c = (k_q == kmax_q) || (dk_c == '0);
`else
    last_c = (k_q == kmax_q);
`endif
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      l_q         <= '0;
      s_q         <= '0;
      mask_q      <= '0;
      k_q         <= '0;
      kmax_q      <= '0;
      min_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      distance_q  <= '0;
      error_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      l_q         <= l_d;
      s_q         <= s_d;
      mask_q      <= mask_d;
      k_q         <= k_d;
      kmax_q      <= kmax_d;
      min_q       <= min_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      distance_q  <= distance_d;
      error_q     <= error_d;
      busy_q      <= busy_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    l_d         = l_q;
    s_d         = s_q;
    mask_d      = mask_q;
    k_d         = k_q;
    kmax_d      = kmax_q;
    min_d       = min_q;
    out_valid_d = out_valid_q;
    distance_d  = distance_q;
    error_d     = error_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready_q) begin
          l_d    = a_is_l_c ? val_a : val_b;
          s_d    = a_is_l_c ? val_b : val_a;
          mask_d = mask_wide_c[W-1:0];
          kmax_d = a_is_l_c ? (len_a - len_b) : (len_b - len_a);
          k_d    = '0;
          min_d  = '1;
          // Illegal pair skips SCAN; the all-ones min becomes the reported distance
          error_d = !len_ok_c;
          state_d = len_ok_c ? ST_SCAN : ST_DONE;
        end
      end
      ST_SCAN: begin
        min_d = (dk_c < min_q) ? dk_c : min_q;
        k_d   = k_q + LW'(1);
        if (last_c) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        // First DONE cycle publishes the final minimum, then holds for the handshake
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          distance_d  = min_q;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    in_ready_d = (state_d == ST_IDLE);
    busy_d     = (state_d != ST_IDLE);
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign distance  = distance_q;
  assign error     = error_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_icblbc_align_distance.sv
// Directed bench for icblbc_align_distance: distances, latencies, errors, backpressure, reset.
module tb_icblbc_align_distance;

  localparam int unsigned W  = 8;
  localparam int unsigned DW = 4;

`ifdef ICBLBC_EARLY_EXIT_EN
  localparam int LAT_ZERO = 2;
`else
  localparam int LAT_ZERO = 4;
`endif

  logic          clock;
  logic          reset_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  val_a;
  logic [3:0]    len_a;
  logic [W-1:0]  val_b;
  logic [3:0]    len_b;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] distance;
  logic          error;
  logic          busy;

  int total = 0;
  int bad   = 0;
  int lat;

  icblbc_align_distance #(.W(W), .DW(DW)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .val_a     (val_a),
    .len_a     (len_a),
    .val_b     (val_b),
    .len_b     (len_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .distance  (distance),
    .error     (error),
    .busy      (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one pair for a single accepting edge (edge N); returns #1 after N
  task automatic start(input logic [7:0] a, input logic [3:0] la,
                       input logic [7:0] b, input logic [3:0] lb);
    val_a    = a;
    len_a    = la;
    val_b    = b;
    len_b    = lb;
    in_valid = 1'b1;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
  endtask

  // Edges after the accepting edge until out_valid is seen (bounded)
  task automatic wait_valid(output int n);
    n = 0;
    while (out_valid !== 1'b1 && n < 100) begin
      @(posedge clock);
      #1;
      n++;
    end
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    out_ready = 1'b0;
    chk({tag, "_ov_clr"}, 32'(out_valid), 32'd0);
    chk({tag, "_rdy"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    val_a     = '0;
    len_a     = '0;
    val_b     = '0;
    len_b     = '0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_distance", 32'(distance), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    // out_ready with nothing pending has no effect
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    out_ready = 1'b0;
    chk("idle_ordy_ov", 32'(out_valid), 32'd0);
    chk("idle_ordy_rdy", 32'(in_ready), 32'd1);

    // 1: three alignments, each at distance 1
    start(8'b1010, 4'd4, 8'b11, 4'd2);
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_in_ready", 32'(in_ready), 32'd0);
    wait_valid(lat);
    chk("t1_lat", 32'(lat), 32'd4);
    chk("t1_dist", 32'(distance), 32'd1);
    chk("t1_err", 32'(error), 32'd0);
    handshake("t1");

    // 2: zero distance at k=0
    start(8'b1011, 4'd4, 8'b11, 4'd2);
    wait_valid(lat);
    chk("t2_lat", 32'(lat), 32'(LAT_ZERO));
    chk("t2_dist", 32'(distance), 32'd0);
    handshake("t2");

    // 3: equal lengths, single alignment, and the swapped pair
    start(8'hFF, 4'd8, 8'h00, 4'd8);
    wait_valid(lat);
    chk("t3_lat", 32'(lat), 32'd2);
    chk("t3_dist", 32'(distance), 32'd8);
    handshake("t3");
    start(8'h00, 4'd8, 8'hFF, 4'd8);
    wait_valid(lat);
    chk("t3s_lat", 32'(lat), 32'd2);
    chk("t3s_dist", 32'(distance), 32'd8);
    handshake("t3s");

    // Longer B, min 1 over six alignments
    start(8'b101, 4'd3, 8'b1100_0110, 4'd8);
    wait_valid(lat);
    chk("t3b_lat", 32'(lat), 32'd7);
    chk("t3b_dist", 32'(distance), 32'd1);
    handshake("t3b");

    // 4: illegal lengths
    start(8'h0F, 4'd4, 8'h03, 4'd0);
    wait_valid(lat);
    chk("t4a_lat", 32'(lat), 32'd1);
    chk("t4a_err", 32'(error), 32'd1);
    chk("t4a_dist", 32'(distance), 32'hF);
    handshake("t4a");
    start(8'h0F, 4'd9, 8'h03, 4'd2);
    wait_valid(lat);
    chk("t4b_lat", 32'(lat), 32'd1);
    chk("t4b_err", 32'(error), 32'd1);
    chk("t4b_dist", 32'(distance), 32'hF);
    handshake("t4b");

    // 5: backpressure in DONE with ignored in_valid pulses
    start(8'b1010, 4'd4, 8'b11, 4'd2);
    wait_valid(lat);
    chk("t5_lat", 32'(lat), 32'd4);
    chk("t5_err", 32'(error), 32'd0);
    for (int i = 0; i < 5; i++) begin
      val_a    = 8'hFF;
      len_a    = 4'd8;
      val_b    = 8'h00;
      len_b    = 4'd8;
      in_valid = i[0];
      @(posedge clock);
      #1;
      chk("t5_hold_ov", 32'(out_valid), 32'd1);
      chk("t5_hold_dist", 32'(distance), 32'd1);
      chk("t5_hold_rdy", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    handshake("t5");
    @(posedge clock);
    #1;
    chk("t5_not_queued_busy", 32'(busy), 32'd0);
    chk("t5_not_queued_ov", 32'(out_valid), 32'd0);
    chk("t5_dist_kept", 32'(distance), 32'd1);

    // 6: reset in the second SCAN cycle, then a fresh pair
    start(8'b1010, 4'd4, 8'b11, 4'd2);
    @(posedge clock);
    #1;
    reset_n = 1'b0;
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    chk("t6_rdy", 32'(in_ready), 32'd1);
    chk("t6_ov", 32'(out_valid), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_dist", 32'(distance), 32'd0);
    start(8'b1100_0110, 4'd8, 8'b101, 4'd3);
    wait_valid(lat);
    chk("t6n_lat", 32'(lat), 32'd7);
    chk("t6n_dist", 32'(distance), 32'd1);
    chk("t6n_err", 32'(error), 32'd0);
    handshake("t6n");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
